// File: rtl/ldpc_frame_feeder_pkg.sv
// ldpc_frame_feeder_pkg
//   Shared definitions for the LDPC frame feeder:
//   - CNT_W       : width of the per-frame byte counter
//   - state_t     : feeder FSM state encoding
//   - k_bytes()   : MODCOD -> K (information bytes per BBFRAME, Kldpc/8)
package ldpc_frame_feeder_pkg;

    localparam int CNT_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_PAD    = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // Unlisted MODCODs (0, 1, 29-31) fall back to the rate 1/4 frame.
    function automatic logic [CNT_W-1:0] k_bytes(input logic [4:0] modcod);
        logic [CNT_W-1:0] k;
        case (modcod)
            5'd2:                          k = 13'd2700;
            5'd3:                          k = 13'd3240;
            5'd4:                          k = 13'd4050;
            5'd5, 5'd12:                   k = 13'd4860;
            5'd6, 5'd13, 5'd18:            k = 13'd5400;
            5'd7, 5'd14, 5'd19, 5'd24:     k = 13'd6075;
            5'd8, 5'd20, 5'd25:            k = 13'd6480;
            5'd9, 5'd15, 5'd21, 5'd26:     k = 13'd6750;
            5'd10, 5'd16, 5'd22, 5'd27:    k = 13'd7200;
            5'd11, 5'd17, 5'd23, 5'd28:    k = 13'd7290;
            default:                       k = 13'd2025;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ldpc_frame_feeder.sv
// ldpc_frame_feeder
//   Feeds BBFRAME information bytes into an LDPC encoder. Each frame is
//   exactly K bytes (K chosen by the MODCOD sampled with the SOF byte);
//   a frame cut short by a new SOF is zero-padded to K bytes.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   s_sof/s_modcod/s_data/s_valid/s_ready   upstream byte stream
//   enc_rdy           encoder idle, waiting for SOF
//   enc_sof/enc_modcod/enc_din/enc_din_valid   encoder-side byte stream
//   busy              frame in progress
//   frame_done        pulse with the K-th byte
//   err_early_sof     pulse when a frame is truncated by a new SOF
//   err_no_sof        pulse when a non-SOF byte is dropped in IDLE
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an SOF byte while the encoder reports ready
// STREAM | forwarding upstream bytes, counting down to K
// PAD    | frame truncated; issuing zero bytes until K are out
// GAP    | frame complete; waiting for enc_rdy to fall and rise again
module ldpc_frame_feeder
    import ldpc_frame_feeder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_sof,
    input  logic [4:0] s_modcod,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       enc_rdy,
    output logic       enc_sof,
    output logic [4:0] enc_modcod,
    output logic [7:0] enc_din,
    output logic       enc_din_valid,
    output logic       busy,
    output logic       frame_done,
    output logic       err_early_sof,
    output logic       err_no_sof
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_low_q, seen_low_d;
    logic             ready_c;

    logic             sof_d, dv_d, busy_d, done_d, early_d, nosof_d;
    logic [7:0]       din_d;
    logic [4:0]       mc_d;

    // Reset gating keeps s_ready low while rst_n is asserted.
    assign s_ready = ready_c & rst_n;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seen_low_d = seen_low_q;
        ready_c    = 1'b0;
        sof_d      = 1'b0;
        dv_d       = 1'b0;
        din_d      = enc_din;
        mc_d       = enc_modcod;
        done_d     = 1'b0;
        early_d    = 1'b0;
        nosof_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // An SOF byte is held upstream until the encoder is ready.
                ready_c = ~(s_valid & s_sof & ~enc_rdy);
                if (s_valid && ready_c) begin
                    if (s_sof) begin
                        sof_d      = 1'b1;
                        dv_d       = 1'b1;
                        din_d      = s_data;
                        mc_d       = s_modcod;
                        cnt_d      = k_bytes(s_modcod) - 13'd1;
                        seen_low_d = 1'b0;
                        state_d    = ST_STREAM;
                    end else begin
                        nosof_d = 1'b1;
                    end
                end
            end

            ST_STREAM: begin
                // A new SOF is refused so it can open the next frame later.
                ready_c    = ~(s_valid & s_sof);
                seen_low_d = seen_low_q | ~enc_rdy;
                if (s_valid) begin
                    if (s_sof) begin
                        early_d = 1'b1;
                        state_d = ST_PAD;
                    end else begin
                        dv_d  = 1'b1;
                        din_d = s_data;
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 13'd1;
                        end
                        if (cnt_q <= 13'd1) begin
                            done_d  = 1'b1;
                            state_d = ST_GAP;
                        end
                    end
                end
            end

            ST_PAD: begin
                seen_low_d = seen_low_q | ~enc_rdy;
                dv_d       = 1'b1;
                din_d      = 8'h00;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 13'd1;
                end
                if (cnt_q <= 13'd1) begin
                    done_d  = 1'b1;
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                // Leave only after the encoder has dropped and re-raised
                // enc_rdy, so a new SOF never lands on a busy encoder.
                if (!enc_rdy) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            seen_low_q    <= 1'b0;
            enc_sof       <= 1'b0;
            enc_modcod    <= '0;
            enc_din       <= '0;
            enc_din_valid <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            err_early_sof <= 1'b0;
            err_no_sof    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            seen_low_q    <= seen_low_d;
            enc_sof       <= sof_d;
            enc_modcod    <= mc_d;
            enc_din       <= din_d;
            enc_din_valid <= dv_d;
            busy          <= busy_d;
            frame_done    <= done_d;
            err_early_sof <= early_d;
            err_no_sof    <= nosof_d;
        end
    end

endmodule

// File: tb/tb_ldpc_frame_feeder.sv
// tb_ldpc_frame_feeder
//   Directed sequence with random payload bytes, checked against frame-level
//   expectations (K table, byte order, padding length, pulse counts).
module tb_ldpc_frame_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_sof = 1'b0;
    logic [4:0] s_modcod = '0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       enc_rdy = 1'b0;
    logic       enc_sof;
    logic [4:0] enc_modcod;
    logic [7:0] enc_din;
    logic       enc_din_valid;
    logic       busy;
    logic       frame_done;
    logic       err_early_sof;
    logic       err_no_sof;

    ldpc_frame_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .s_sof(s_sof), .s_modcod(s_modcod), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready),
        .enc_rdy(enc_rdy), .enc_sof(enc_sof), .enc_modcod(enc_modcod),
        .enc_din(enc_din), .enc_din_valid(enc_din_valid), .busy(busy),
        .frame_done(frame_done), .err_early_sof(err_early_sof),
        .err_no_sof(err_no_sof)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int sof_total = 0, early_total = 0, nosof_total = 0;

    logic       r_ready, r_sof, r_dv, r_busy, r_done, r_early, r_nosof;
    logic [7:0] r_din;
    logic [4:0] r_mc;
    logic       prev_r_sof = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bytes per frame, straight from the MODCOD/code-rate table.
    function automatic int k_of(input int mc);
        case (mc)
            2:              return 2700;
            3:              return 3240;
            4:              return 4050;
            5, 12:          return 4860;
            6, 13, 18:      return 5400;
            7, 14, 19, 24:  return 6075;
            8, 20, 25:      return 6480;
            9, 15, 21, 26:  return 6750;
            10, 16, 22, 27: return 7200;
            11, 17, 23, 28: return 7290;
            default:        return 2025;
        endcase
    endfunction

    // One clock cycle: drive inputs, sample at the falling edge, advance.
    // r_ready belongs to this cycle's inputs; registered outputs reflect
    // what was accepted on the previous cycle.
    task automatic cyc(input logic v, input logic sf, input logic [4:0] mc,
                       input logic [7:0] d, input logic rdy);
        s_valid = v; s_sof = sf; s_modcod = mc; s_data = d; enc_rdy = rdy;
        @(negedge clk);
        r_ready = s_ready; r_sof = enc_sof; r_dv = enc_din_valid;
        r_din = enc_din; r_mc = enc_modcod; r_busy = busy;
        r_done = frame_done; r_early = err_early_sof; r_nosof = err_no_sof;
        if (r_sof) begin
            sof_total++;
            check("sof_not_back_to_back", prev_r_sof, 1'b0);
        end
        prev_r_sof = r_sof;
        if (r_early) early_total++;
        if (r_nosof) nosof_total++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = 1'b1; s_sof = 1'b1; enc_rdy = 1'b1;
        #1;
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_enc_sof", enc_sof, 1'b0);
        check("rst_din_valid", enc_din_valid, 1'b0);
        check("rst_enc_din", enc_din, 8'h00);
        check("rst_enc_modcod", enc_modcod, 5'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_err_early", err_early_sof, 1'b0);
        check("rst_err_nosof", err_no_sof, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        s_valid = 1'b0; s_sof = 1'b0; enc_rdy = 1'b1;
        rst_n = 1'b1;
        prev_r_sof = 1'b0;
    endtask

    // Full frame from IDLE; encoder drops enc_rdy once the SOF is taken.
    task automatic stream_frame(input logic [4:0] mc, input bit toggle);
        int         k, sent, got, budget;
        bit         v, prev_acc, prev_first, prev_last;
        logic [7:0] b, prev_b;
        k = k_of(int'(mc));
        sent = 0; got = 0; budget = 4 * k + 100;
        prev_acc = 0; prev_first = 0; prev_last = 0; prev_b = '0;
        while (got < k && budget > 0) begin
            v = (sent < k) && (!toggle || ($urandom_range(1, 0) == 1));
            b = 8'($urandom_range(255, 0));
            cyc(v, sent == 0, (sent == 0) ? mc : 5'($urandom_range(31, 0)), b, sent == 0);
            if (sent < k) check("stream_ready", r_ready, 1'b1);
            check("stream_valid_timing", r_dv, prev_acc);
            check("stream_sof", r_sof, prev_acc && prev_first);
            check("stream_done", r_done, prev_acc && prev_last);
            if (r_dv) begin
                got++;
                check("stream_byte", r_din, prev_b);
                check("stream_modcod", r_mc, mc);
                check("stream_busy", r_busy, 1'b1);
            end
            prev_acc = v; prev_b = b;
            prev_first = (sent == 0); prev_last = (sent == k - 1);
            if (v) sent++;
            budget--;
        end
        check("stream_count", got, k);
    endtask

    task automatic gap_exit();
        cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
        check("gap_busy", r_busy, 1'b1);
        check("gap_ready", r_ready, 1'b0);
        check("gap_no_valid", r_dv, 1'b0);
        cyc(1'b1, 1'b1, 5'd3, 8'h11, 1'b0);
        check("gap_holds_sof", r_ready, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
        check("gap_no_sof", r_sof, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
        check("gap_exit_busy", r_busy, 1'b0);
        check("gap_exit_ready", r_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] bytes_q[$];
        logic [7:0] b, prev_b;
        int         zeros;
        bit         done;

        do_reset();

        // Non-SOF bytes in IDLE are dropped with an error pulse each.
        for (int i = 0; i < 5; i++) begin
            cyc(i < 3, 1'b0, 5'($urandom_range(31, 0)), 8'($urandom_range(255, 0)), 1'b1);
            check("nosof_ready", r_ready, 1'b1);
            check("nosof_pulse", r_nosof, (i >= 1 && i <= 3));
            check("nosof_no_valid", r_dv, 1'b0);
            check("nosof_no_sof", r_sof, 1'b0);
        end

        stream_frame(5'd4, 1'b0);
        gap_exit();
        stream_frame(5'd11, 1'b1);
        gap_exit();

        // Truncated MODCOD 2 frame: 100 bytes, then a new SOF.
        bytes_q.delete();
        for (int i = 0; i < 100; i++) begin
            b = 8'($urandom_range(255, 0));
            cyc(1'b1, i == 0, 5'd2, b, i == 0);
            check("early_ready", r_ready, 1'b1);
            check("early_valid", r_dv, i > 0);
            if (i > 0) check("early_byte", r_din, prev_b);
            prev_b = b;
        end
        cyc(1'b1, 1'b1, 5'd4, 8'hA5, 1'b0);
        check("early_sof_refused", r_ready, 1'b0);
        check("early_last_byte", r_din, prev_b);
        check("early_last_valid", r_dv, 1'b1);
        cyc(1'b1, 1'b1, 5'd4, 8'hA5, 1'b0);
        check("early_pulse", r_early, 1'b1);
        check("early_sof_not_fwd", r_dv, 1'b0);
        check("early_pad_ready", r_ready, 1'b0);
        zeros = 0; done = 0;
        while (!done && zeros < 3000) begin
            cyc(1'b1, 1'b1, 5'd4, 8'hA5, 1'b0);
            check("pad_ready", r_ready, 1'b0);
            check("pad_valid", r_dv, 1'b1);
            check("pad_zero", r_din, 8'h00);
            zeros++;
            if (r_done) done = 1;
        end
        check("pad_count", zeros, k_of(2) - 100);
        check("pad_done", done, 1'b1);
        cyc(1'b1, 1'b1, 5'd4, 8'hA5, 1'b0);
        check("pad_gap_ready", r_ready, 1'b0);
        check("pad_gap_busy", r_busy, 1'b1);
        check("pad_gap_valid", r_dv, 1'b0);
        cyc(1'b1, 1'b1, 5'd4, 8'hA5, 1'b1);
        check("held_sof_gap_ready", r_ready, 1'b0);
        cyc(1'b1, 1'b1, 5'd4, 8'hA5, 1'b1);
        check("held_sof_accept", r_ready, 1'b1);
        cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
        check("held_sof_pulse", r_sof, 1'b1);
        check("held_sof_byte", r_din, 8'hA5);
        check("held_sof_modcod", r_mc, 5'd4);
        do_reset();

        // SOF waits 20 cycles on enc_rdy = 0, then a MODCOD 9 frame is cut
        // by reset after its 1000th byte.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 5'd9, 8'h3C, 1'b0);
            check("wait_rdy_ready", r_ready, 1'b0);
            check("wait_rdy_no_sof", r_sof, 1'b0);
        end
        cyc(1'b1, 1'b1, 5'd9, 8'h3C, 1'b1);
        check("rdy_rise_accept", r_ready, 1'b1);
        prev_b = 8'h3C;
        for (int i = 2; i <= 1000; i++) begin
            b = 8'($urandom_range(255, 0));
            cyc(1'b1, 1'b0, 5'($urandom_range(31, 0)), b, 1'b0);
            if (i == 2) begin
                check("rdy_rise_sof", r_sof, 1'b1);
                check("rdy_rise_modcod", r_mc, 5'd9);
            end
            check("mc9_ready", r_ready, 1'b1);
            check("mc9_valid", r_dv, 1'b1);
            check("mc9_byte", r_din, prev_b);
            prev_b = b;
        end
        check("mc9_before_rst_valid", enc_din_valid, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
            check("post_rst_no_pad", r_dv, 1'b0);
            check("post_rst_idle", r_busy, 1'b0);
        end
        stream_frame(5'd0, 1'b0);
        gap_exit();
        stream_frame(5'd30, 1'b1);
        gap_exit();

        check("total_early_sof", early_total, 1);
        check("total_no_sof", nosof_total, 3);
        check("total_sof", sof_total, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
